// File: rtl/pool2x2_relu_if.sv
// Bus bundle for pool2x2_relu: start/finish control plus the parameter,
// feature-map (read) and pooled-map (write) single-port SRAM ports.
// slave  = the pooling engine side; master = controller/SRAM side.
interface pool2x2_relu_if #(
  parameter int ADDR_W = 32
);
  logic              start;
  logic              finish;
  logic              param_cs;
  logic [ADDR_W-1:0] param_addr;
  logic [31:0]       param_rdata;
  logic              in_cs;
  logic [ADDR_W-1:0] in_addr;
  logic [31:0]       in_rdata;
  logic              out_cs;
  logic [ADDR_W-1:0] out_addr;
  logic              out_w_req;
  logic [31:0]       out_wdata;

  modport slave (
    input  start,
    output finish,
    output param_cs,
    output param_addr,
    input  param_rdata,
    output in_cs,
    output in_addr,
    input  in_rdata,
    output out_cs,
    output out_addr,
    output out_w_req,
    output out_wdata
  );

  modport master (
    output start,
    input  finish,
    input  param_cs,
    input  param_addr,
    output param_rdata,
    input  in_cs,
    input  in_addr,
    output in_rdata,
    input  out_cs,
    input  out_addr,
    input  out_w_req,
    input  out_wdata
  );
endinterface

// File: rtl/pool2x2_relu.sv
// 2x2 / stride-2 max pooling over an int8 channel-major feature map.
// Reads num_row / num_CH from the parameter SRAM, pools each channel
// (floor semantics for odd num_row) and writes one byte per output pixel.
// Optional ReLU on the pooled value: define POOL_RELU_EN.
// All SRAM-facing outputs and finish are registered: the combinational
// block computes next-state values and the register block loads them, so
// an output is visible exactly in the state that owns it.
module pool2x2_relu #(
  parameter int ADDR_W = 32
) (
  input  logic          clk,
  input  logic          rst,
  pool2x2_relu_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    LD_PARM,
    SETUP,
    RD,
    WR,
    FIN
  } state_t;

  state_t            state, state_n;
  logic [2:0]        cnt, cnt_n;
  logic [ADDR_W-1:0] num_row, num_row_n;
  logic [31:0]       num_ch, num_ch_n;
  logic [ADDR_W-1:0] plane, plane_n;
  logic [ADDR_W-1:0] half, half_n;
  logic [ADDR_W-1:0] ch_base, ch_base_n;
  logic [ADDR_W-1:0] row_base, row_base_n;
  logic [ADDR_W-1:0] col, col_n;
  logic [ADDR_W-1:0] row_cnt, row_cnt_n;
  logic [31:0]       ch_cnt, ch_cnt_n;
  logic [ADDR_W-1:0] out_idx, out_idx_n;
  logic [7:0]        pmax, pmax_n;
  logic [7:0]        pix;
  logic [7:0]        result;

  logic              finish_q, finish_n;
  logic              param_cs_q, param_cs_n;
  logic [ADDR_W-1:0] param_addr_q, param_addr_n;
  logic              in_cs_q, in_cs_n;
  logic [ADDR_W-1:0] in_addr_q, in_addr_n;
  logic              out_cs_q, out_cs_n;
  logic [ADDR_W-1:0] out_addr_q, out_addr_n;
  logic              out_w_req_q, out_w_req_n;
  logic [31:0]       out_wdata_q, out_wdata_n;

  logic              in_rdata_unused;

  assign pix             = bus.in_rdata[7:0];
  assign in_rdata_unused = ^bus.in_rdata[31:8];

  assign bus.finish     = finish_q;
  assign bus.param_cs   = param_cs_q;
  assign bus.param_addr = param_addr_q;
  assign bus.in_cs      = in_cs_q;
  assign bus.in_addr    = in_addr_q;
  assign bus.out_cs     = out_cs_q;
  assign bus.out_addr   = out_addr_q;
  assign bus.out_w_req  = out_w_req_q;
  assign bus.out_wdata  = out_wdata_q;

  // State, counters, parameters and registered outputs; async active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      cnt          <= '0;
      num_row      <= '0;
      num_ch       <= '0;
      plane        <= '0;
      half         <= '0;
      ch_base      <= '0;
      row_base     <= '0;
      col          <= '0;
      row_cnt      <= '0;
      ch_cnt       <= '0;
      out_idx      <= '0;
      pmax         <= '0;
      finish_q     <= 1'b0;
      param_cs_q   <= 1'b0;
      param_addr_q <= '0;
      in_cs_q      <= 1'b0;
      in_addr_q    <= '0;
      out_cs_q     <= 1'b0;
      out_addr_q   <= '0;
      out_w_req_q  <= 1'b1;
      out_wdata_q  <= '0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      num_row      <= num_row_n;
      num_ch       <= num_ch_n;
      plane        <= plane_n;
      half         <= half_n;
      ch_base      <= ch_base_n;
      row_base     <= row_base_n;
      col          <= col_n;
      row_cnt      <= row_cnt_n;
      ch_cnt       <= ch_cnt_n;
      out_idx      <= out_idx_n;
      pmax         <= pmax_n;
      finish_q     <= finish_n;
      param_cs_q   <= param_cs_n;
      param_addr_q <= param_addr_n;
      in_cs_q      <= in_cs_n;
      in_addr_q    <= in_addr_n;
      out_cs_q     <= out_cs_n;
      out_addr_q   <= out_addr_n;
      out_w_req_q  <= out_w_req_n;
      out_wdata_q  <= out_wdata_n;
    end
  end

  // Next-state, counter advance and next values of the registered outputs.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    num_row_n   = num_row;
    num_ch_n    = num_ch;
    plane_n     = plane;
    half_n      = half;
    ch_base_n   = ch_base;
    row_base_n  = row_base;
    col_n       = col;
    row_cnt_n   = row_cnt;
    ch_cnt_n    = ch_cnt;
    out_idx_n   = out_idx;
    pmax_n      = pmax;
    result      = pmax;
    out_cs_n    = 1'b0;
    out_w_req_n = 1'b1;
    out_addr_n  = out_addr_q;
    out_wdata_n = out_wdata_q;

    case (state)
      IDLE: begin
        if (bus.start) begin
          state_n = LD_PARM;
          cnt_n   = '0;
        end
      end

      LD_PARM: begin
        cnt_n = cnt + 3'd1;
        if (cnt == 3'd1) begin
          num_row_n = ADDR_W'(bus.param_rdata);
        end
        if (cnt == 3'd2) begin
          num_ch_n = bus.param_rdata;
          state_n  = SETUP;
          cnt_n    = '0;
        end
      end

      SETUP: begin
        plane_n    = num_row * num_row;
        half_n     = num_row >> 1;
        ch_base_n  = '0;
        row_base_n = '0;
        col_n      = '0;
        row_cnt_n  = '0;
        ch_cnt_n   = '0;
        out_idx_n  = '0;
        cnt_n      = '0;
        if ((num_row < ADDR_W'(2)) || (num_ch == '0)) begin
          state_n = FIN;
        end else begin
          state_n = RD;
        end
      end

      RD: begin
        if (cnt == 3'd0) begin
          cnt_n = 3'd1;
        end else begin
          // Tap 0 seeds the running max; later taps keep the signed larger.
          if ((cnt == 3'd1) || ($signed(pix) > $signed(pmax))) begin
            pmax_n = pix;
          end
          if (cnt == 3'd4) begin
`ifdef POOL_RELU_EN
            result = pmax_n[7] ? 8'h00 : pmax_n;
`else
            result = pmax_n;
`endif
            state_n     = WR;
            cnt_n       = '0;
            out_cs_n    = 1'b1;
            out_w_req_n = 1'b0;
            out_addr_n  = out_idx;
            out_wdata_n = {24'h0, result};
          end else begin
            cnt_n = cnt + 3'd1;
          end
        end
      end

      WR: begin
        out_idx_n = out_idx + ADDR_W'(1);
        state_n   = RD;
        cnt_n     = '0;
        if ((col + ADDR_W'(2)) == (half << 1)) begin
          col_n = '0;
          if ((row_cnt + ADDR_W'(1)) == half) begin
            row_cnt_n  = '0;
            row_base_n = '0;
            ch_base_n  = ch_base + plane;
            ch_cnt_n   = ch_cnt + 32'd1;
            if ((ch_cnt + 32'd1) == num_ch) begin
              state_n = FIN;
            end
          end else begin
            row_cnt_n  = row_cnt + ADDR_W'(1);
            row_base_n = row_base + (num_row << 1);
          end
        end else begin
          col_n = col + ADDR_W'(2);
        end
      end

      FIN: begin
        state_n = IDLE;
      end

      default: begin
        state_n = IDLE;
      end
    endcase

    finish_n     = (state_n == FIN);
    param_cs_n   = (state_n == LD_PARM) && (cnt_n < 3'd2);
    param_addr_n = param_cs_n ? (ADDR_W'(cnt_n) + ADDR_W'(1)) : param_addr_q;
    in_cs_n      = (state_n == RD) && (cnt_n < 3'd4);
    // Tap address is formed from the counters as they will be in the
    // issuing cycle, so the SRAM sees it in the same cycle in_cs rises.
    in_addr_n    = in_cs_n ?
                   (ch_base_n + row_base_n + col_n +
                    (cnt_n[1] ? num_row : '0) + ADDR_W'(cnt_n[0])) :
                   in_addr_q;
  end

endmodule

// File: tb/tb_pool2x2_relu.sv
// Self-checking bench for pool2x2_relu: SRAM models, a pooling reference
// model computed directly from the input array, and a per-cycle compare
// process that checks every presented write against the model.
module tb_pool2x2_relu;

  logic clk = 1'b0;
  logic rst;

  pool2x2_relu_if #(.ADDR_W(32)) bus ();

  pool2x2_relu #(.ADDR_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int          n_vec;
  int          n_fail;
  logic [31:0] in_mem  [0:1023];
  logic [31:0] out_mem [0:255];
  int          out_job [0:255];
  int          rd_job  [0:1023];
  int          wr_total = 0;
  int          pres;
  int          job_id;
  int          job_base;
  int          rd_limit;
  int          act;
  int          dact;
  int          p_nr;
  int          p_nch;
  logic [7:0]  exp_q [$];

  // SRAM models: one-cycle read latency, write on cs with active-low w_req.
  always @(posedge clk) begin
    if (bus.param_cs)
      bus.param_rdata <= (bus.param_addr == 32'd1) ? 32'(p_nr) :
                         (bus.param_addr == 32'd2) ? 32'(p_nch) : 32'hBAD0_0000;
    if (bus.in_cs)
      bus.in_rdata <= (bus.in_addr < 32'd1024) ? in_mem[bus.in_addr[9:0]] : 32'hDEAD_BEEF;
    if (rst && bus.out_cs && !bus.out_w_req) begin
      wr_total <= wr_total + 1;
      if (bus.out_addr < 32'd256) begin
        out_mem[bus.out_addr[7:0]] <= bus.out_wdata;
        out_job[bus.out_addr[7:0]] <= job_id;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, want);
    end
  endtask

  task automatic check_reset(input string nm);
    chk({nm, "_ctl"}, {27'h0, bus.out_cs, bus.out_w_req, bus.finish, bus.in_cs, bus.param_cs}, 32'h8);
    chk({nm, "_addr_data"}, bus.out_addr | bus.in_addr | bus.param_addr | bus.out_wdata, 32'h0);
  endtask

  // Reference: floor 2x2 max pooling, channel-major raster output order.
  task automatic build_model(input int nr, input int nch);
    int R;
    logic signed [7:0] m;
    logic signed [7:0] v;
    logic [31:0] w;
    exp_q.delete();
    R = nr / 2;
    if (nr < 2) return;
    for (int ch = 0; ch < nch; ch++)
      for (int r = 0; r < R; r++)
        for (int c = 0; c < R; c++) begin
          m = -8'sd128;
          for (int dy = 0; dy < 2; dy++)
            for (int dx = 0; dx < 2; dx++) begin
              w = in_mem[ch * nr * nr + (2 * r + dy) * nr + 2 * c + dx];
              v = w[7:0];
              if (v > m) m = v;
            end
`ifdef POOL_RELU_EN
          if (m < 0) m = 8'sd0;
`endif
          exp_q.push_back(m);
        end
  endtask

  task automatic fill_random(input int n);
    for (int a = 0; a < n; a++) in_mem[a] = $urandom();
  endtask

  // Compare process: every presented write must match the model in order.
  task automatic monitor();
    int idx;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (bus.in_cs || bus.out_cs) dact++;
        if (bus.in_cs || bus.out_cs || bus.param_cs || bus.finish) act++;
        if (bus.in_cs) begin
          chk("rd_range", {31'h0, bus.in_addr < 32'(rd_limit)}, 32'h1);
          if (bus.in_addr < 32'd1024) rd_job[bus.in_addr[9:0]] = job_id;
        end
        if (bus.out_cs) begin
          idx = pres - job_base;
          pres++;
          chk("wr_req_low", {31'h0, bus.out_w_req}, 32'h0);
          if (idx < exp_q.size()) begin
            chk("wr_addr", bus.out_addr, 32'(idx));
            chk("wr_data", bus.out_wdata, {24'h0, exp_q[idx]});
          end else begin
            chk("wr_extra", 32'(idx), 32'(exp_q.size()));
          end
        end
      end
    end
  endtask

  task automatic run_job(input int nr, input int nch, input int inject_at, input int abort_at);
    int R, P, n, plane, bad, wr_base, act_base, dact_base, r, c;
    bit seen, should;
    p_nr = nr;
    p_nch = nch;
    R = nr / 2;
    P = (nr >= 2) ? nch * R * R : 0;
    plane = nr * nr;
    rd_limit = nch * plane;
    build_model(nr, nch);
    job_id++;
    job_base = pres;
    wr_base = wr_total;
    dact_base = dact;
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    n = 0;
    seen = 0;
    while (!seen && n < 4 + 6 * P + 40) begin
      @(posedge clk);
      n++;
      #1;
      bus.start = (n == inject_at);
      if (abort_at != 0 && n == abort_at) begin
        chk("abort_in_wr", {30'h0, bus.out_cs, bus.out_w_req}, 32'h2);
        rst = 1'b0;
        #1 check_reset("abort_rst");
        repeat (3) @(posedge clk);
        #1 check_reset("abort_hold");
        @(negedge clk) rst = 1'b1;
        wr_base = wr_total;
        act_base = act;
        repeat (4 + 6 * P + 10) @(posedge clk);
        #1;
        chk("abort_no_wr", 32'(wr_total - wr_base), 32'h0);
        chk("abort_idle", 32'(act - act_base), 32'h0);
        return;
      end
      if (bus.finish) seen = 1;
    end
    chk("finish_latency", seen ? 32'(n) : 32'hFFFF_FFFF, 32'(4 + 6 * P));
    @(posedge clk);
    #1 chk("finish_pulse", {31'h0, bus.finish}, 32'h0);
    chk("wr_count", 32'(wr_total - wr_base), 32'(P));
    chk("wr_presented", 32'(pres - job_base), 32'(P));
    bad = 0;
    for (int i = 0; i < P; i++)
      if (out_job[i] != job_id || out_mem[i] !== {24'h0, exp_q[i]}) bad++;
    chk("mem_contents", 32'(bad), 32'h0);
    bad = 0;
    for (int a = 0; a < rd_limit; a++) begin
      r = (a % plane) / nr;
      c = a % nr;
      should = (P > 0) && (r < 2 * R) && (c < 2 * R);
      if ((rd_job[a] == job_id) != should) bad++;
    end
    chk("read_set", 32'(bad), 32'h0);
    if (P == 0) chk("no_data_act", 32'(dact - dact_base), 32'h0);
  endtask

  initial begin
    logic [7:0] lit [8];
    int nr, nch;
    rst = 1'b0;
    bus.start = 1'b0;
    n_vec = 0;
    n_fail = 0;
    pres = 0;
    job_id = 0;
    job_base = 0;
    rd_limit = 0;
    act = 0;
    dact = 0;
    p_nr = 0;
    p_nch = 0;
    for (int a = 0; a < 1024; a++) rd_job[a] = -1;
    fork
      monitor();
    join_none

    repeat (3) @(posedge clk);
    #1 check_reset("reset_state");
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1 check_reset("idle_state");

    // 4x4 raster ramp
    for (int a = 0; a < 16; a++) in_mem[a] = {24'($urandom()), 8'(a)};
    build_model(4, 1);
    lit = '{8'd5, 8'd7, 8'd13, 8'd15, 8'd0, 8'd0, 8'd0, 8'd0};
    for (int i = 0; i < 4; i++) chk("model_ramp", {24'h0, exp_q[i]}, {24'h0, lit[i]});
    run_job(4, 1, 0, 0);

    // All negative, one larger negative
    for (int a = 0; a < 16; a++) in_mem[a] = {24'($urandom()), (a == 5) ? 8'hFF : 8'hFD};
    build_model(4, 1);
`ifdef POOL_RELU_EN
    lit = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
`else
    lit = '{8'hFF, 8'hFD, 8'hFD, 8'hFD, 8'h00, 8'h00, 8'h00, 8'h00};
`endif
    for (int i = 0; i < 4; i++) chk("model_neg", {24'h0, exp_q[i]}, {24'h0, lit[i]});
    run_job(4, 1, 0, 0);

    // 5x5, 2 channels, odd size
    for (int ch = 0; ch < 2; ch++)
      for (int a = 0; a < 25; a++) in_mem[ch * 25 + a] = {24'($urandom()), 8'(a + ch)};
    build_model(5, 2);
    lit = '{8'd6, 8'd8, 8'd16, 8'd18, 8'd7, 8'd9, 8'd17, 8'd19};
    for (int i = 0; i < 8; i++) chk("model_5x5", {24'h0, exp_q[i]}, {24'h0, lit[i]});
    run_job(5, 2, 0, 0);

    // Degenerate sizes
    run_job(1, 1, 0, 0);
    run_job(4, 0, 0, 0);
    run_job(0, 3, 0, 0);

    // Reset during the third write, then a clean rerun
    fill_random(16);
    run_job(4, 1, 0, 21);
    run_job(4, 1, 0, 0);

    // Start pulse while reading is ignored
    fill_random(32);
    run_job(4, 2, 6, 0);

    // Random sizes and data
    for (int k = 0; k < 10; k++) begin
      nr = $urandom_range(7, 2);
      nch = $urandom_range(3, 1);
      fill_random(nr * nr * nch);
      run_job(nr, nch, 0, 0);
    end

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
